logreg_mac_sequencer: RTL
=========================

# logreg_mac_sequencer

Controller that sequences one logistic-regression inference on a single shared multiply-accumulate path. On `start` it walks a feature memory and a weight memory in lockstep, accumulates the signed fixed-point dot product, adds the bias, and thresholds the logit into a predicted label with a `done` pulse. It sits between the feature/weight block RAMs and the `ypred`/`done` outputs of the logistic-regression top level.

## Interface
- `N_FEAT`, 4, number of features; the bias sits at weight address `N_FEAT`
- `DW`, 16, feature/weight/bias width, signed Q(DW-FRAC).FRAC
- `FRAC`, 8, fractional bits of the inputs; products and `z` carry 2*FRAC fractional bits
- `AW`, `$clog2(N_FEAT+1)`, memory address width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request one inference; sampled only in IDLE
- `busy`  out  1  high from the edge that accepts `start` until the edge that raises `done`
- `mem_rd`  out  1  read enable shared by both memories
- `mem_addr`  out  AW  shared read address, registered
- `feat_data`  in  DW  feature memory output; synchronous read, valid one cycle after address
- `wt_data`  in  DW  weight memory output; same timing
- `z`  out  2*DW  logit, signed Q(2*DW-2*FRAC).(2*FRAC)
- `ypred`  out  1  predicted label, 1 when `z >= 0`
- `done`  out  1  one-cycle pulse when `z` and `ypred` update

## Operation
- FSM states:
  - IDLE: waits for `start`; `start` moves it to RUN.
  - RUN: issues addresses `0..N_FEAT`.
  - DRAIN: collects the last two read returns.
  - After DRAIN the FSM returns to IDLE and asserts `done`.
- Product: `feat_data*wt_data` is full 2*DW signed. The accumulator `acc` is 2*DW signed and cleared when `start` is accepted.
- Bias: `wt_data` at address `N_FEAT` is sign-extended to 2*DW and shifted left by FRAC, then added. `feat_data` at that address is ignored.
- `ypred` is the inverted sign bit of the final sum, so `z == 0` gives `ypred = 1`, equivalent to sigmoid(z) >= 0.5.
- `z` and `ypred` hold their values until the next `done`.
- `start` while `busy` is ignored and not queued.
- `start` during the `done` cycle is accepted, so back-to-back inferences are possible.
- Reset mid-inference aborts the run: the FSM goes to IDLE, no `done` is issued, and `z`/`ypred` are cleared.
- Reset values: `busy`, `mem_rd`, `mem_addr`, `z`, `ypred`, `done` are all 0; `acc` is 0; the FSM is in IDLE.

## Timing
- Edge 0 samples `start`. At that edge: `busy`←1, `mem_rd`←1, `mem_addr`←0, `acc`←0.
- Edges 1..N_FEAT: `mem_addr`←edge index. Edge N_FEAT+1: `mem_rd`←0.
- Data for address i is captured at edge i+2:
  - edges 2..N_FEAT+1 accumulate the products;
  - edge N_FEAT+2 adds the bias and loads `z`, `ypred`, `done`←1, `busy`←0, FSM←IDLE.
- Latency from start to done is N_FEAT+2 edges (6 for the default). The next inference can start one edge later, giving a throughput of one result per N_FEAT+3 cycles.
- `done` is high for exactly one cycle after edge N_FEAT+2.

## Configuration
- Macro: `LOGREG_SAT_EN`.
- When defined, every accumulator add (products and bias) saturates to [-2^(2*DW-1), 2^(2*DW-1)-1].
- When undefined, adds wrap modulo 2^(2*DW).
- Timing is identical in both builds.

## Test plan
Defaults are `N_FEAT=4`, `DW=16`, `FRAC=8`.
- **Nominal:** features 0x0100,0x0200,0xFF00,0x0080; weights 0x0080,0x0040,0x0100,0x0200; bias 0xFF80; pulse `start`.
  - `done` pulses 6 edges later.
  - `z`=0x00008000, `ypred`=1.
  - `mem_addr` steps 0..4 with `mem_rd` high for 5 cycles.
- **Negative result:** same features and weights, bias 0xFE80 → `z`=0xFFFF8000, `ypred`=0.
- **Zero boundary:** bias 0xFF00 → `z`=0, `ypred`=1.
- **Overflow:** all features and weights 0x7FFF, bias 0.
  - With `LOGREG_SAT_EN`: `z`=0x7FFFFFFF, `ypred`=1.
  - Without it: `z`=0xFFFC0004, `ypred`=0.
- **Handshake corners:**
  - `start` held high throughout `busy`: exactly one `done`.
  - `start` in the `done` cycle: a second `done` arrives 6 edges later.
  - `rst` at edge 3: no `done`; all outputs are 0 the cycle after; a fresh `start` then completes normally.

Source files
------------

// File: rtl/logreg_mac_sequencer.sv
// Sequences one logistic-regression MAC pass; done follows start by N_FEAT+2 edges, and start is ignored while busy.
// Define LOGREG_SAT_EN to make every accumulator add saturate instead of wrapping.
module logreg_mac_sequencer #(
  parameter int N_FEAT = 4,
  parameter int DW     = 16,
  parameter int FRAC   = 8,
  parameter int AW     = $clog2(N_FEAT + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  output logic            o_busy,
  output logic            o_mem_rd,
  output logic [AW-1:0]   o_mem_addr,
  input  logic [DW-1:0]   i_feat_data,
  input  logic [DW-1:0]   i_wt_data,
  output logic [2*DW-1:0] o_z,
  output logic            o_ypred,
  output logic            o_done
);

  localparam int CW = $clog2(N_FEAT + 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic signed [2*DW-1:0] r_acc;

  logic                   w_accept;
  logic                   w_issue;
  logic                   w_rd_off;
  logic                   w_acc_en;
  logic                   w_bias_en;

  logic signed [2*DW-1:0] w_feat_ext;
  logic signed [2*DW-1:0] w_wt_ext;
  logic signed [2*DW-1:0] w_prod;
  logic signed [2*DW-1:0] w_bias;
  logic signed [2*DW-1:0] w_addend;
  logic signed [2*DW-1:0] w_sum;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // r_cnt holds (edges since start - 1) while busy
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == CW'(N_FEAT - 1)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_cnt == CW'(N_FEAT + 1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept  = (r_state == S_IDLE) && i_start;
    w_issue   = (r_state == S_RUN);
    w_rd_off  = (r_state == S_DRAIN);
    w_acc_en  = (r_state != S_IDLE) && (r_cnt != '0) && (r_cnt <= CW'(N_FEAT));
    w_bias_en = (r_state == S_DRAIN) && (r_cnt == CW'(N_FEAT + 1));
  end

  assign w_feat_ext = {{DW{i_feat_data[DW-1]}}, i_feat_data};
  assign w_wt_ext   = {{DW{i_wt_data[DW-1]}}, i_wt_data};
  assign w_prod     = w_feat_ext * w_wt_ext;
  assign w_bias     = w_wt_ext <<< FRAC;
  assign w_addend   = w_bias_en ? w_bias : w_prod;

`ifdef LOGREG_SAT_EN
  logic [2*DW:0] w_sum_wide;
  assign w_sum_wide = {r_acc[2*DW-1], r_acc} + {w_addend[2*DW-1], w_addend};
  // Disagreeing top two bits mean the add left the 2*DW range
  assign w_sum = (w_sum_wide[2*DW] != w_sum_wide[2*DW-1])
               ? (w_sum_wide[2*DW] ? {1'b1, {(2*DW-1){1'b0}}} : {1'b0, {(2*DW-1){1'b1}}})
               : w_sum_wide[2*DW-1:0];
`else
  assign w_sum = r_acc + w_addend;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_busy     <= 1'b0;
      o_mem_rd   <= 1'b0;
      o_mem_addr <= '0;
      o_z        <= '0;
      o_ypred    <= 1'b0;
      o_done     <= 1'b0;
      r_acc      <= '0;
      r_cnt      <= '0;
    end else begin
      o_done <= 1'b0;
      if (w_accept) begin
        o_busy     <= 1'b1;
        o_mem_rd   <= 1'b1;
        o_mem_addr <= '0;
        r_acc      <= '0;
        r_cnt      <= '0;
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_issue)  o_mem_addr <= AW'(r_cnt + 1'b1);
      if (w_rd_off) o_mem_rd   <= 1'b0;
      if (w_acc_en) r_acc      <= w_sum;
      if (w_bias_en) begin
        o_z     <= w_sum;
        o_ypred <= ~w_sum[2*DW-1];
        o_done  <= 1'b1;
        o_busy  <= 1'b0;
      end
    end
  end

endmodule
